// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency, fully pipelined 16-bit word memory responder.
// Storage updates and read sampling happen on the acceptance edge. The result
// then travels through a LATENCY-deep pipeline of {valid, wr, err, rdata}.
module dmem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned AW      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic        rsp_wr,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LAST  = LATENCY - 1;

    typedef struct packed {
        logic          valid;
        logic          wr;
        logic          err;
        logic [DW-1:0] rdata;
    } stage_t;

    logic [DW-1:0] mem [DEPTH];
    stage_t        pipe_q [LATENCY];
    stage_t        stage_in_c;
    logic          ready_q;
    logic          busy_q;
    logic          busy_next_c;
    logic          accept_c;
    logic          misaligned_c;
    logic [AW-1:0] word_idx_c;

    assign accept_c     = req_valid & ready_q;
    assign misaligned_c = req_addr[0];
    assign word_idx_c   = req_addr[AW:1];

    // Upper address bits alias away and are intentionally not decoded.
    if (AW < 15) begin : g_alias
        logic unused_addr_c;
        assign unused_addr_c = ^req_addr[15:AW+1];
    end

    // Entry for pipeline stage 0: a response record, or an all-zero bubble.
    always_comb begin
        stage_in_c = '0;
        if (accept_c) begin
            stage_in_c.valid = 1'b1;
            stage_in_c.wr    = req_wr;
            stage_in_c.err   = misaligned_c;
            if (!req_wr && !misaligned_c) begin
                stage_in_c.rdata = mem[word_idx_c];
            end
        end
    end

    // Busy next cycle: any valid bit present after this edge's shift.
    always_comb begin
        busy_next_c = stage_in_c.valid;
        for (int i = 0; i < int'(LATENCY) - 1; i++) begin
            busy_next_c = busy_next_c | pipe_q[i].valid;
        end
    end

    // Storage has no reset, so committed contents survive rst_n.
    always_ff @(posedge clk) begin
        if (accept_c && req_wr && !misaligned_c) begin
            mem[word_idx_c] <= req_wdata;
        end
    end

    // Response pipeline, ready and busy. Reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LATENCY); i++) begin
                pipe_q[i] <= '0;
            end
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pipe_q[0] <= stage_in_c;
            for (int i = 1; i < int'(LATENCY); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            ready_q <= 1'b1;
            busy_q  <= busy_next_c;
        end
    end

    assign req_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = pipe_q[LAST].valid;
    assign rsp_wr    = pipe_q[LAST].wr;
    assign rsp_err   = pipe_q[LAST].err;
    assign rsp_rdata = pipe_q[LAST].rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Two instances are used, with
// LATENCY 4 and 1, and both are driven with the same stimulus. A queue-based
// reference model predicts every output on every cycle.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    logic        d4_ready, d4_valid, d4_wr, d4_err, d4_busy;
    logic [15:0] d4_rdata;
    logic        d1_ready, d1_valid, d1_wr, d1_err, d1_busy;
    logic [15:0] d1_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.LATENCY(4), .AW(10)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(d4_ready),
        .rsp_valid(d4_valid), .rsp_wr(d4_wr), .rsp_rdata(d4_rdata),
        .rsp_err(d4_err), .busy(d4_busy)
    );

    dmem_responder #(.LATENCY(1), .AW(10)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(d1_ready),
        .rsp_valid(d1_valid), .rsp_wr(d1_wr), .rsp_rdata(d1_rdata),
        .rsp_err(d1_err), .busy(d1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a word array plus per-latency queues of expected responses.
    typedef struct packed {
        int          due;
        logic        wr;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    logic [15:0] mmem [1024];
    exp_t        q4 [$];
    exp_t        q1 [$];
    logic        m_ready = 1'b0;
    int          last_edge = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Model update: the acceptance edge samples storage, then commits the write.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   idx;
        if (!rst_n) begin
            q4.delete();
            q1.delete();
            m_ready = 1'b0;
        end else begin
            last_edge++;
            if (m_ready && req_valid) begin
                idx     = int'(req_addr[10:1]);
                e       = '0;
                e.wr    = req_wr;
                e.err   = req_addr[0];
                e.rdata = (!req_wr && !req_addr[0]) ? mmem[idx] : 16'h0000;
                e.due   = last_edge + 3;
                q4.push_back(e);
                e.due   = last_edge;
                q1.push_back(e);
                if (req_wr && !req_addr[0]) mmem[idx] = req_wdata;
            end
            m_ready = 1'b1;
        end
    end

    function automatic void cmp_dut(string tag, bit have, exp_t e, bit bexp,
                                    logic rdy, logic v, logic w, logic er,
                                    logic [15:0] rd, logic b);
        chk({tag, ".req_ready"}, 32'(rdy), 32'(m_ready));
        chk({tag, ".rsp_valid"}, 32'(v),   32'(have));
        chk({tag, ".rsp_wr"},    32'(w),   have ? 32'(e.wr)    : 32'd0);
        chk({tag, ".rsp_err"},   32'(er),  have ? 32'(e.err)   : 32'd0);
        chk({tag, ".rsp_rdata"}, 32'(rd),  have ? 32'(e.rdata) : 32'd0);
        chk({tag, ".busy"},      32'(b),   32'(bexp));
    endfunction

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e4, e1;
        bit   h4, h1, b4, b1;
        b4 = q4.size() > 0;
        b1 = q1.size() > 0;
        h4 = b4 && (q4[0].due == last_edge);
        h1 = b1 && (q1[0].due == last_edge);
        e4 = h4 ? q4[0] : '0;
        e1 = h1 ? q1[0] : '0;
        if (h4) void'(q4.pop_front());
        if (h1) void'(q1.pop_front());
        cmp_dut("L4", h4, e4, b4, d4_ready, d4_valid, d4_wr, d4_err, d4_rdata, d4_busy);
        cmp_dut("L1", h1, e1, b1, d1_ready, d1_valid, d1_wr, d1_err, d1_rdata, d1_busy);
    end

    // Present one request for one edge; returns at the following negedge.
    task automatic issue(input logic v, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
        req_valid = v;
        req_wr    = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [15:0] a;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_ready", 32'(d4_ready), 32'd0);
        chk("reset_busy",  32'(d4_busy),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 32'(d4_ready), 32'd1);

        // Fill every word so that all later reads are well defined.
        for (int i = 0; i < 1024; i++) issue(1'b1, 1'b1, 16'(i * 2), 16'($urandom));
        idle(5);

        // Write then read the same word on the next edge.
        issue(1'b1, 1'b1, 16'h0010, 16'h1234);
        chk("L1_wr_rsp_valid", 32'(d1_valid), 32'd1);
        chk("L1_wr_rsp_wr",    32'(d1_wr),    32'd1);
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);
        chk("L1_rd_rdata", 32'(d1_rdata), 32'h1234);
        idle(2);
        chk("wr_rsp_valid", 32'(d4_valid), 32'd1);
        chk("wr_rsp_wr",    32'(d4_wr),    32'd1);
        chk("wr_rsp_rdata", 32'(d4_rdata), 32'd0);
        idle(1);
        chk("rd_after_wr_valid", 32'(d4_valid), 32'd1);
        chk("rd_after_wr_rdata", 32'(d4_rdata), 32'h1234);
        idle(3);

        // Back-to-back reads return in order.
        issue(1'b1, 1'b1, 16'h0000, 16'h000A);
        issue(1'b1, 1'b1, 16'h0002, 16'h000B);
        issue(1'b1, 1'b1, 16'h0004, 16'h000C);
        idle(4);
        issue(1'b1, 1'b0, 16'h0000, 16'h0000);
        chk("b2b_busy_first", 32'(d4_busy), 32'd1);
        issue(1'b1, 1'b0, 16'h0002, 16'h0000);
        issue(1'b1, 1'b0, 16'h0004, 16'h0000);
        idle(1);
        chk("b2b_rd0", 32'(d4_rdata), 32'h000A);
        idle(1);
        chk("b2b_rd1", 32'(d4_rdata), 32'h000B);
        idle(1);
        chk("b2b_rd2",       32'(d4_rdata), 32'h000C);
        chk("b2b_busy_last", 32'(d4_busy),  32'd1);
        idle(1);
        chk("b2b_idle_valid", 32'(d4_valid), 32'd0);
        chk("b2b_idle_busy",  32'(d4_busy),  32'd0);

        // A misaligned write flags an error and leaves storage untouched.
        issue(1'b1, 1'b1, 16'h0011, 16'hFFFF);
        idle(3);
        chk("mis_err",   32'(d4_err),   32'd1);
        chk("mis_rdata", 32'(d4_rdata), 32'd0);
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(3);
        chk("mis_unchanged", 32'(d4_rdata), 32'h1234);

        // Upper address bits alias.
        issue(1'b1, 1'b1, 16'h0806, 16'h5A5A);
        issue(1'b1, 1'b0, 16'h0006, 16'h0000);
        idle(3);
        chk("alias_rdata", 32'(d4_rdata), 32'h5A5A);
        idle(2);

        // Alternating valid: the L1 instance echoes the pattern one cycle later.
        for (int i = 0; i < 16; i++) begin
            issue(1'((i % 2) == 0), 1'b0, 16'(($urandom_range(0, 63)) * 2), 16'h0000);
            chk("alt_L1_valid", 32'(d1_valid), 32'((i % 2) == 0));
        end
        idle(5);

        // Asynchronous reset with reads in flight.
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);
        issue(1'b1, 1'b0, 16'h0002, 16'h0000);
        issue(1'b1, 1'b0, 16'h0004, 16'h0000);
        idle(0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_L4_busy",  32'(d4_busy),  32'd0);
        chk("arst_L4_ready", 32'(d4_ready), 32'd0);
        chk("arst_L1_valid", 32'(d1_valid), 32'd0);
        chk("arst_L1_rdata", 32'(d1_rdata), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_back", 32'(d4_ready), 32'd1);
        idle(8);
        issue(1'b1, 1'b0, 16'h0010, 16'h0000);
        idle(3);
        chk("arst_storage_kept", 32'(d4_rdata), 32'h1234);
        idle(2);

        // Randomized traffic, concentrated on a small address window.
        for (int i = 0; i < 600; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 1) a[10:5] = 6'd0;
            a[0] = ($urandom_range(0, 7) == 0);
            issue(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, 16'($urandom));
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
